instr_sram_resp: RTL and testbench

// - Responder end of the fetch-stage instruction SRAM interface (en/we/addr/wdata -> instr).
// - Word-organised synchronous memory with 1-cycle read latency; instr holds while en=0, so stalled fetch data stays stable.
// - Boot FSM clears the array to NOP, then raises boot_done; top keeps the fetch stage in reset until then.
// - Side loader port writes program words while fetch is idle; out-of-range and misaligned fetch accesses are counted.

---
 rtl/instr_sram_resp.sv | 117 +++++++++++
 tb/tb_instr_sram_resp.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/instr_sram_resp.sv
// Instruction SRAM responder: single-port word memory with 1-cycle registered read,
// boot-time NOP clear, side loader port and a saturating bad-access counter.
module instr_sram_resp #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned AW        = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP       = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_sram_en,
  input  logic          instr_sram_we,
  input  logic [31:0]   instr_sram_addr,
  input  logic [31:0]   instr_sram_wdata,
  output logic [31:0]   instr,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic          boot_done,
  output logic [7:0]    err_cnt
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t        state_reg;
  logic [AW-1:0] clr_idx_reg;
  logic [31:0]   instr_reg;
  logic          boot_done_reg;
  logic [7:0]    err_cnt_reg;

  logic [31:0]   mem [DEPTH];

  // Decode at word granularity; BASE_ADDR is word-aligned so the low bits drop out.
  logic [29:0]   off_w;
  logic          in_range;
  logic          aligned;
  logic          addr_ok;
  logic [AW-1:0] idx;

  assign off_w    = instr_sram_addr[31:2] - BASE_ADDR[31:2];
  assign in_range = (off_w[29:AW] == '0);
  assign aligned  = (instr_sram_addr[1:0] == 2'b00);
  assign addr_ok  = in_range && aligned;
  assign idx      = off_w[AW-1:0];

  // Fetch always has priority; the loader only gets the port on idle cycles.
  assign ld_ready = (state_reg == S_RUN) && !instr_sram_en;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = idx;
    mem_wdata = instr_sram_wdata;
    if (!reset) begin
      if (state_reg == S_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_reg;
        mem_wdata = NOP;
      end else if (instr_sram_en && instr_sram_we && addr_ok) begin
        mem_we = 1'b1;
      end else if (ld_valid && ld_ready) begin
        mem_we    = 1'b1;
        mem_waddr = ld_addr;
        mem_wdata = ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_CLEAR;
      clr_idx_reg   <= '0;
      instr_reg     <= NOP;
      boot_done_reg <= 1'b0;
      err_cnt_reg   <= 8'h00;
    end else begin
      case (state_reg)
        S_CLEAR: begin
          clr_idx_reg <= clr_idx_reg + 1'b1;
          if (clr_idx_reg == LAST_IDX) begin
            state_reg     <= S_RUN;
            boot_done_reg <= 1'b1;
          end
        end
        S_RUN: begin
          if (instr_sram_en) begin
            // Reads of bad addresses return NOP rather than aliased data.
            if (!instr_sram_we) begin
              instr_reg <= addr_ok ? mem[idx] : NOP;
            end
            if (!addr_ok && (err_cnt_reg != 8'hFF)) begin
              err_cnt_reg <= err_cnt_reg + 8'h01;
            end
          end
        end
        default: state_reg <= S_CLEAR;
      endcase
    end
  end

  assign instr     = instr_reg;
  assign boot_done = boot_done_reg;
  assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_instr_sram_resp.sv
// Directed bench for instr_sram_resp at DEPTH=16: boot clear, loader, priority,
// bad-access counting and read-after-write.
module tb_instr_sram_resp;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk;
  logic          reset;
  logic          instr_sram_en;
  logic          instr_sram_we;
  logic [31:0]   instr_sram_addr;
  logic [31:0]   instr_sram_wdata;
  logic [31:0]   instr;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          boot_done;
  logic [7:0]    err_cnt;

  int vectors;
  int miscompares;

  instr_sram_resp #(
    .DEPTH(DEPTH),
    .AW(AW),
    .BASE_ADDR(32'h0000_0000),
    .NOP(NOP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .instr_sram_en(instr_sram_en),
    .instr_sram_we(instr_sram_we),
    .instr_sram_addr(instr_sram_addr),
    .instr_sram_wdata(instr_sram_wdata),
    .instr(instr),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .boot_done(boot_done),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at negedge; outputs are checked at the following negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic fetch(input logic en, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    instr_sram_en    = en;
    instr_sram_we    = we;
    instr_sram_addr  = addr;
    instr_sram_wdata = wdata;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    fetch(1'b0, 1'b0, 32'h0, 32'h0);
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_data  = 32'h0;

    @(negedge clk);
    tick();
    check("rst_instr", instr, NOP);
    check("rst_boot_done", {31'b0, boot_done}, 32'h0);
    check("rst_err_cnt", {24'b0, err_cnt}, 32'h0);
    check("rst_ld_ready", {31'b0, ld_ready}, 32'h0);

    // Start a clear, then reset again once clr_idx has reached 7.
    reset = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("midclear_boot_done", {31'b0, boot_done}, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // 16 clear cycles with boot_done low; early ones carry fetch traffic that must be ignored.
    for (int i = 0; i < 16; i++) begin
      if (i < 8) fetch(1'b1, (i % 2) == 0, 32'h0000_0041, 32'hFFFF_FFFF);
      else       fetch(1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check($sformatf("boot_low_c%0d", i + 1), {31'b0, boot_done}, 32'h0);
      check($sformatf("boot_ldrdy_c%0d", i + 1), {31'b0, ld_ready}, 32'h0);
      tick();
      check($sformatf("boot_instr_c%0d", i + 1), instr, NOP);
    end
    check("boot_done_c17", {31'b0, boot_done}, 32'h1);
    check("boot_err_cnt", {24'b0, err_cnt}, 32'h0);

    // Loader write idx2, then fetch it back.
    ld_valid = 1'b1;
    ld_addr  = 4'd2;
    ld_data  = 32'hDEAD_BEEF;
    #1;
    check("ld_ready_idle", {31'b0, ld_ready}, 32'h1);
    tick();
    ld_valid = 1'b0;
    fetch(1'b1, 1'b0, 32'h0000_0008, 32'h0);
    #1;
    check("ld_ready_busy", {31'b0, ld_ready}, 32'h0);
    tick();
    check("rd_idx2", instr, 32'hDEAD_BEEF);
    fetch(1'b0, 1'b0, 32'h0000_0040, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_c%0d", i + 1), instr, 32'hDEAD_BEEF);
    end

    // Loader held against two fetch reads of idx3; accepted on the first idle cycle.
    ld_valid = 1'b1;
    ld_addr  = 4'd3;
    ld_data  = 32'hCAFE_F00D;
    for (int i = 0; i < 2; i++) begin
      fetch(1'b1, 1'b0, 32'h0000_000C, 32'h0);
      #1;
      check($sformatf("prio_ld_ready_c%0d", i + 1), {31'b0, ld_ready}, 32'h0);
      tick();
      check($sformatf("prio_no_write_c%0d", i + 1), instr, NOP);
    end
    fetch(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("prio_ld_ready_idle", {31'b0, ld_ready}, 32'h1);
    tick();
    ld_valid = 1'b0;
    fetch(1'b1, 1'b0, 32'h0000_000C, 32'h0);
    tick();
    check("prio_rd_idx3", instr, 32'hCAFE_F00D);

    // Misaligned and out-of-range reads return NOP and count.
    fetch(1'b1, 1'b0, 32'h0000_0041, 32'h0);
    tick();
    check("bad_0x41_instr", instr, NOP);
    check("bad_0x41_err", {24'b0, err_cnt}, 32'h1);
    fetch(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    tick();
    check("bad_0x40_instr", instr, NOP);
    check("bad_0x40_err", {24'b0, err_cnt}, 32'h2);

    // Fetch write leaves instr alone; next-cycle read sees the new word.
    fetch(1'b1, 1'b0, 32'h0000_0008, 32'h0);
    tick();
    fetch(1'b1, 1'b1, 32'h0000_0004, 32'h0010_0093);
    tick();
    check("wr_instr_unchanged", instr, 32'hDEAD_BEEF);
    fetch(1'b1, 1'b0, 32'h0000_0004, 32'h0);
    tick();
    check("raw_idx1", instr, 32'h0010_0093);

    // Misaligned and out-of-range (aliasing idx1) writes are dropped but counted.
    fetch(1'b1, 1'b1, 32'h0000_0006, 32'hFFFF_FFFF);
    tick();
    fetch(1'b1, 1'b1, 32'h0000_0044, 32'h1111_1111);
    tick();
    check("bad_wr_err", {24'b0, err_cnt}, 32'h4);
    fetch(1'b1, 1'b0, 32'h0000_0004, 32'h0);
    tick();
    check("bad_wr_dropped", instr, 32'h0010_0093);
    check("good_rd_no_err", {24'b0, err_cnt}, 32'h4);

    // 300 bad reads: reaches 8'hFF after 251, then saturates.
    for (int i = 0; i < 300; i++) begin
      fetch(1'b1, 1'b0, 32'h0000_0041, 32'h0);
      tick();
      if (i == 250) check("sat_reach_ff", {24'b0, err_cnt}, 32'hFF);
      if (i == 249) check("sat_pre_fe", {24'b0, err_cnt}, 32'hFE);
    end
    check("sat_hold_ff", {24'b0, err_cnt}, 32'hFF);
    fetch(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("final_instr", instr, NOP);
    check("final_boot_done", {31'b0, boot_done}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
